// File: rtl/mips_mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS datapath and its controller FSM.
//   Datapath -> FSM : op[5:0], funct[5:0], zero
//   FSM -> datapath : i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
//                     alu_src_a, alu_src_b[1:0], alu_control[2:0], pc_src[1:0], pc_en,
//                     state[3:0] (debug)
// master: datapath side, slave: controller side.
interface mips_mc_control_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [3:0] state;

  modport master (
    output op, funct, zero,
    input  i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, alu_control, pc_src, pc_en, state
  );

  modport slave (
    input  op, funct, zero,
    output i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
           alu_src_b, alu_control, pc_src, pc_en, state
  );
endinterface

// File: rtl/mips_mc_control_fsm.sv
// Multicycle MIPS controller (lw, sw, R-type, beq, addi, j).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, forces FETCH
//   bus   : control bundle (slave side), see mips_mc_control_fsm_if
// Datapath controls are Moore outputs of the state; pc_en and alu_control
// also depend on zero and funct respectively.
module mips_mc_control_fsm (
  input logic                  clk,
  input logic                  reset,
  mips_mc_control_fsm_if.slave bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] r_state;
  logic [3:0] w_next;

  logic       w_i_or_d, w_ir_write, w_mem_write, w_reg_write;
  logic       w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_pc_src, w_alu_op;
  logic       w_pc_write, w_branch;
  logic [2:0] w_alu_control;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      w_next = S_MEMRD;
        else if (bus.op == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_i_or_d     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_src     = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = 1'b1;
        w_pc_write  = 1'b1;
        w_alu_src_b = 2'b01;
      end
      S_DECODE: w_alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: w_i_or_d = 1'b1;
      S_MEMWR: begin
        w_i_or_d    = 1'b1;
        w_mem_write = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
      end
      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_control = 3'b010;
    case (w_alu_op)
      2'b01: w_alu_control = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100010: w_alu_control = 3'b110;
          6'b100100: w_alu_control = 3'b000;
          6'b100101: w_alu_control = 3'b001;
          6'b101010: w_alu_control = 3'b111;
          default:   w_alu_control = 3'b010;
        endcase
      end
      default: w_alu_control = 3'b010;
    endcase
  end

  // Write enables are masked by reset itself so nothing commits while it is held,
  // even in the delta before the state register reaches FETCH.
  assign bus.i_or_d      = w_i_or_d;
  assign bus.ir_write    = w_ir_write & ~reset;
  assign bus.mem_write   = w_mem_write & ~reset;
  assign bus.reg_write   = w_reg_write & ~reset;
  assign bus.reg_dst     = w_reg_dst;
  assign bus.mem_to_reg  = w_mem_to_reg;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.pc_src      = w_pc_src;
  assign bus.alu_control = w_alu_control;
  assign bus.pc_en       = (w_pc_write | (w_branch & bus.zero)) & ~reset;
  assign bus.state       = r_state;

endmodule
